icache: RTL and testbench
=========================

# icache

Direct-mapped, one-word-per-line instruction cache that sits upstream of the CPU core. It serves the core's fetch address with same-cycle data on a hit and stalls the fetch on a miss. During a miss it fetches the word from the external instruction memory over a req/ack handshake. It replaces the zero-latency ROM model so the core can run from slow memory.

## Interface
Parameters:
- `IDX_W`, 4: index width; `LINES = 2**IDX_W` lines.
- `ADDR_W`, 32: address width; tag width is `ADDR_W-2-IDX_W`.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-low.
- `romAddr_i`, input, 32: fetch address from the core's `romAddr_o`.
- `romData_o`, output, 32: instruction to the core's `romData_i`.
- `stall_o`, output, 1: fetch not satisfied this cycle; the core holds its PC and IF/ID.
- `flush_i`, input, 1: invalidate all lines.
- `memReq_o`, output, 1: request to external memory, level-held.
- `memAddr_o`, output, 32: word-aligned request address (bits [1:0] = 0).
- `memAck_i`, input, 1: one-cycle pulse; `memData_i` is valid in the same cycle.
- `memData_i`, input, 32: returned word.
- `hitCount_o`, output, 32: present only with `ICACHE_STATS_EN`.
- `missCount_o`, output, 32: present only with `ICACHE_STATS_EN`.

## Operation
- Address split:
  - index = `romAddr_i[2+IDX_W-1:2]`.
  - tag = `romAddr_i[31:2+IDX_W]`.
  - bits [1:0] are ignored.
- Storage per line: valid bit, tag, 32-bit data. Only the valid bits are reset.
- FSM states: IDLE and REQ.
- IDLE:
  - hit = valid[index] && tag match.
  - On a hit: `romData_o` = line data (combinational), `stall_o` = 0.
  - On a miss: `stall_o` = 1, `romData_o` = 0. Latch the aligned address into `memAddr_o` and go to REQ.
- REQ:
  - `memReq_o` = 1 and `stall_o` = 1. `memAddr_o` is held stable.
  - Changes on `romAddr_i` are ignored.
  - On `memAck_i`: write tag/data into the latched line, set valid, return to IDLE. `memReq_o` drops at that edge.
- `memAck_i` while in IDLE is ignored.
- Flush:
  - `flush_i` clears every valid bit at the edge.
  - In IDLE, the lookup in the flush cycle still uses the pre-flush valid bits.
  - `flush_i` and `memAck_i` together: the line is not marked valid, the FSM returns to IDLE, and the next lookup misses again.
  - Flush in REQ without ack: the request continues; the fill completes normally.
- A line written by a fill replaces whatever the line held (no associativity, no write-back).

## Timing
- Values while `rst` is low:
  - `memReq_o`=0, `memAddr_o`=0, FSM=IDLE, all valid=0.
  - `stall_o`=0, `romData_o`=0 (forced).
  - counters=0.
- Hit latency: 0 cycles (combinational path from `romAddr_i`).
- Miss timeline:
  - Cycle 0: miss detected.
  - Cycle 1: `memReq_o` rises.
  - Ack in cycle A: the line is written at the end of A.
  - Cycle A+1: hit, `stall_o`=0.
  - Miss penalty = A+1 cycles; minimum 2 (ack in cycle 1).
- Reset asserted mid-REQ: `memReq_o` drops immediately and the in-flight ack is ignored. External memory must tolerate an abandoned request.
- Back-to-back misses: IDLE of cycle A+1 can detect a new miss, giving a new `memReq_o` in A+2.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `hitCount_o` increments on each IDLE cycle with a hit.
  - `missCount_o` increments on each IDLE→REQ transition.
  - Both saturate at 32'hFFFF_FFFF.
  - `flush_i` does not clear the counters; only reset does.
- Not defined: counters and ports are absent; behaviour is otherwise identical.

## Structure
- `icache_pkg` holds:
  - the state encoding (IDLE=1'b0, REQ=1'b1);
  - the default `IDX_W`;
  - the tag/index slice helper constants.
- Sub-module `icache_store`: the valid/tag/data array with
  - async-clear valid bits;
  - one write port (index, tag, data, we);
  - one combinational read port;
  - a global invalidate input.
- The top level holds the FSM, request registers and counters.

## Test plan
- Reset, then `romAddr_i`=0x0000_0000 with memory ack latency 3 → `memReq_o` in cycles 1–3, `memAddr_o`=0x0; `stall_o`=0 with `romData_o`=memory word in cycle 4; `missCount_o`=1.
- Sequential fetches 0x00..0x3C (first pass), then a repeat of the same 16 addresses → each first access misses once, the repeat yields 16 hits with no `memReq_o`, `hitCount_o`=16.
- Conflict: fetch 0x0000_0004 then 0x0000_0044 (same index, different tag), then 0x04 again → three misses, and the line returns the 0x04 data last.
- `flush_i` pulsed while IDLE on a valid line 0x08 → the next fetch of 0x08 misses with `memAddr_o`=0x08.
- `flush_i` coincident with `memAck_i` for 0x10 → FSM returns to IDLE, the next cycle re-requests 0x10.
- `rst` low while in REQ, then ack arrives after release → `memReq_o`=0 immediately, the ack is ignored, and fetch 0x10 issues a fresh request.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: FSM encoding, default geometry
// and the constants used to slice a fetch address into offset/index/tag.
package icache_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    localparam int DEF_IDX_W  = 4;
    localparam int DEF_ADDR_W = 32;

    // Byte offset inside a 32-bit word; the index field starts right above it.
    localparam int OFF_W   = 2;
    localparam int IDX_LSB = OFF_W;

    function automatic int tag_width(input int addr_w, input int idx_w);
        return addr_w - OFF_W - idx_w;
    endfunction

endpackage

// File: rtl/icache_store.sv
// Line storage for the direct-mapped instruction cache: valid/tag/data per line,
// one write port, one combinational read port and a global invalidate.
module icache_store
    import icache_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W,
    parameter int TAG_W = tag_width(DEF_ADDR_W, DEF_IDX_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inval_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [TAG_W-1:0] wtag_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic             rvalid_o,
    output logic [TAG_W-1:0] rtag_o,
    output logic [31:0]      rdata_o
);

    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    // Invalidate wins over a same-cycle fill so the filled line stays invalid.
    always_comb begin
        valid_d = valid_q;
        if (inval_i) begin
            valid_d = '0;
        end else if (we_i) begin
            valid_d[widx_i] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits: the only storage that is cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays are written on every fill and never reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a req/ack miss path.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache
    import icache_pkg::*;
#(
    parameter int IDX_W  = DEF_IDX_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] romAddr_i,
    output logic [31:0]       romData_o,
    output logic              stall_o,
    input  logic              flush_i,
    output logic              memReq_o,
    output logic [ADDR_W-1:0] memAddr_o,
    input  logic              memAck_i,
    input  logic [31:0]       memData_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hitCount_o,
    output logic [31:0]       missCount_o
`endif
);

    localparam int TAG_W = tag_width(ADDR_W, IDX_W);

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    logic [IDX_W-1:0]  lk_idx_s;
    logic [TAG_W-1:0]  lk_tag_s;
    logic              rd_valid_s;
    logic [TAG_W-1:0]  rd_tag_s;
    logic [31:0]       rd_data_s;
    logic              hit_s;
    logic              miss_s;
    logic              fill_s;

    assign lk_idx_s = romAddr_i[IDX_LSB +: IDX_W];
    assign lk_tag_s = romAddr_i[ADDR_W-1 -: TAG_W];
    assign fill_s   = (state_q == ST_REQ) && memAck_i;

    icache_store #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst),
        .inval_i  (flush_i),
        .we_i     (fill_s),
        .widx_i   (addr_q[IDX_LSB +: IDX_W]),
        .wtag_i   (addr_q[ADDR_W-1 -: TAG_W]),
        .wdata_i  (memData_i),
        .ridx_i   (lk_idx_s),
        .rvalid_o (rd_valid_s),
        .rtag_o   (rd_tag_s),
        .rdata_o  (rd_data_s)
    );

    // Lookup only happens in IDLE; while a fill is pending the fetch address is ignored.
    always_comb begin
        hit_s  = 1'b0;
        miss_s = 1'b0;
        if (state_q == ST_IDLE) begin
            hit_s  = rd_valid_s && (rd_tag_s == lk_tag_s);
            miss_s = !hit_s;
        end else begin
            hit_s  = 1'b0;
            miss_s = 1'b0;
        end
    end

    // Core-facing outputs are forced quiet while reset is held.
    always_comb begin
        stall_o   = 1'b0;
        romData_o = 32'd0;
        if (!rst) begin
            stall_o   = 1'b0;
            romData_o = 32'd0;
        end else begin
            stall_o   = (state_q == ST_REQ) || miss_s;
            romData_o = hit_s ? rd_data_s : 32'd0;
        end
    end

    // Miss FSM: latch the word-aligned address on a miss, wait for the ack.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (miss_s) begin
                    state_d              = ST_REQ;
                    addr_d               = romAddr_i;
                    addr_d[OFF_W-1:0]    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (memAck_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = addr_q;
            end
        endcase
    end

    // FSM state and request address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign memReq_o  = (state_q == ST_REQ);
    assign memAddr_o = addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] hit_cnt_d;
    logic [31:0] miss_cnt_q;
    logic [31:0] miss_cnt_d;

    // Saturating event counters; a flush leaves them untouched.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_s && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
        if (miss_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hitCount_o  = hit_cnt_q;
    assign missCount_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: fetch sequences with a scripted memory responder,
// expected fetch data held in a scoreboard queue and popped when stall_o drops.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] romAddr_i;
    logic [31:0] romData_o;
    logic        stall_o;
    logic        flush_i;
    logic        memReq_o;
    logic [31:0] memAddr_o;
    logic        memAck_i;
    logic [31:0] memData_i;
`ifdef ICACHE_STATS_EN
    logic [31:0] hitCount_o;
    logic [31:0] missCount_o;
    logic [31:0] hc0;
    logic [31:0] mc0;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb_q[$];

    icache dut (
        .clk       (clk),
        .rst       (rst),
        .romAddr_i (romAddr_i),
        .romData_o (romData_o),
        .stall_o   (stall_o),
        .flush_i   (flush_i),
        .memReq_o  (memReq_o),
        .memAddr_o (memAddr_o),
        .memAck_i  (memAck_i),
        .memData_i (memData_i)
`ifdef ICACHE_STATS_EN
        ,
        .hitCount_o  (hitCount_o),
        .missCount_o (missCount_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1234_0001 + (a * 32'd7);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic sb_pop_check(input string tag);
        logic [31:0] e;
        checks++;
        assert (sb_q.size() != 0) else begin
            failures++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check(tag, romData_o, e);
        end
    endtask

    // One fetch: drive address, check cycle 0, serve a miss with ack after lat cycles.
    task automatic fetch(input logic [31:0] a, input int lat, input logic exp_miss);
        @(posedge clk); #1;
        romAddr_i = a;
        sb_q.push_back(mem_word(a));
        @(negedge clk);
        check_bit("stall_c0", stall_o, exp_miss);
        if (!exp_miss) begin
            check_bit("req_on_hit", memReq_o, 1'b0);
            sb_pop_check("hit_data");
        end else begin
            for (int c = 1; c <= lat; c++) begin
                @(posedge clk); #1;
                memAck_i  = (c == lat);
                memData_i = (c == lat) ? mem_word(a) : 32'hBAD0_BAD0;
                @(negedge clk);
                check_bit("memReq_wait", memReq_o, 1'b1);
                check("memAddr_wait", memAddr_o, {a[31:2], 2'b00});
                check_bit("stall_wait", stall_o, 1'b1);
            end
            @(posedge clk); #1;
            memAck_i = 1'b0;
            @(negedge clk);
            check_bit("stall_after_fill", stall_o, 1'b0);
            check_bit("req_dropped", memReq_o, 1'b0);
            sb_pop_check("fill_data");
        end
    endtask

    // Flush pulse on a cycle whose lookup must still hit on pre-flush valid bits.
    task automatic flush_on_hit(input logic [31:0] a);
        @(posedge clk); #1;
        romAddr_i = a;
        flush_i   = 1'b1;
        sb_q.push_back(mem_word(a));
        @(negedge clk);
        check_bit("flush_cycle_stall", stall_o, 1'b0);
        sb_pop_check("flush_cycle_data");
        @(posedge clk); #1;
        flush_i = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        romAddr_i = 32'd0;
        flush_i   = 1'b0;
        memAck_i  = 1'b0;
        memData_i = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check_bit("rst_memReq", memReq_o, 1'b0);
        check("rst_memAddr", memAddr_o, 32'd0);
        check_bit("rst_stall", stall_o, 1'b0);
        check("rst_romData", romData_o, 32'd0);
`ifdef ICACHE_STATS_EN
        check("rst_hitCount", hitCount_o, 32'd0);
        check("rst_missCount", missCount_o, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;

        // First miss, ack latency 3.
        fetch(32'h0000_0000, 3, 1'b1);
`ifdef ICACHE_STATS_EN
        @(posedge clk); #1;
        check("first_missCount", missCount_o, 32'd1);
        check("first_hitCount", hitCount_o, 32'd1);
`endif

        // Flush on a valid line, then two passes over 16 sequential words.
        flush_on_hit(32'h0000_0000);
        for (int i = 0; i < 16; i++) begin
            fetch(32'(i * 4), (i % 4) + 1, 1'b1);
        end
`ifdef ICACHE_STATS_EN
        @(posedge clk); #1;
        hc0 = hitCount_o;
        mc0 = missCount_o;
`endif
        for (int i = 0; i < 16; i++) begin
            fetch(32'(i * 4), 1, 1'b0);
        end
`ifdef ICACHE_STATS_EN
        @(posedge clk); #1;
        // 16 repeat hits plus the idle hit cycle spent taking the first snapshot.
        check("pass2_hit_delta", hitCount_o - hc0, 32'd17);
        check("pass2_miss_delta", missCount_o - mc0, 32'd0);
`endif

        // Conflict on index 1.
        flush_on_hit(32'h0000_0004);
        fetch(32'h0000_0004, 2, 1'b1);
        fetch(32'h0000_0044, 1, 1'b1);
        fetch(32'h0000_0004, 2, 1'b1);
        fetch(32'h0000_0004, 1, 1'b0);

        // Flush while idle on valid line 0x08.
        fetch(32'h0000_0008, 1, 1'b1);
        flush_on_hit(32'h0000_0008);
        fetch(32'h0000_0008, 2, 1'b1);

        // Flush coincident with ack for 0x10.
        @(posedge clk); #1;
        romAddr_i = 32'h0000_0010;
        @(negedge clk);
        check_bit("fa_stall_c0", stall_o, 1'b1);
        @(posedge clk); #1;
        memAck_i  = 1'b1;
        memData_i = mem_word(32'h0000_0010);
        flush_i   = 1'b1;
        @(negedge clk);
        check_bit("fa_req_c1", memReq_o, 1'b1);
        @(posedge clk); #1;
        memAck_i = 1'b0;
        flush_i  = 1'b0;
        @(negedge clk);
        check_bit("fa_idle_req", memReq_o, 1'b0);
        check_bit("fa_remiss_stall", stall_o, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("fa_rereq", memReq_o, 1'b1);
        check("fa_rereq_addr", memAddr_o, 32'h0000_0010);
        @(posedge clk); #1;
        memAck_i  = 1'b1;
        memData_i = mem_word(32'h0000_0010);
        sb_q.push_back(mem_word(32'h0000_0010));
        @(posedge clk); #1;
        memAck_i = 1'b0;
        @(negedge clk);
        check_bit("fa_fill_stall", stall_o, 1'b0);
        sb_pop_check("fa_fill_data");

        // Reset asserted mid-request, stray ack after release.
        @(posedge clk); #1;
        romAddr_i = 32'h0000_0014;
        @(negedge clk);
        check_bit("rr_stall_c0", stall_o, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("rr_req", memReq_o, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_bit("rr_req_drop", memReq_o, 1'b0);
        check_bit("rr_stall_forced", stall_o, 1'b0);
        check("rr_addr_reset", memAddr_o, 32'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst       = 1'b1;
        romAddr_i = 32'h0000_0010;
        memAck_i  = 1'b1;
        memData_i = 32'hDEAD_BEEF;
        @(negedge clk);
        check_bit("rr_ack_ignored_req", memReq_o, 1'b0);
        check_bit("rr_new_miss", stall_o, 1'b1);
        @(posedge clk); #1;
        memAck_i = 1'b0;
        @(negedge clk);
        check_bit("rr_fresh_req", memReq_o, 1'b1);
        check("rr_fresh_addr", memAddr_o, 32'h0000_0010);
        @(posedge clk); #1;
        memAck_i  = 1'b1;
        memData_i = mem_word(32'h0000_0010);
        sb_q.push_back(mem_word(32'h0000_0010));
        @(posedge clk); #1;
        memAck_i = 1'b0;
        @(negedge clk);
        check_bit("rr_fill_stall", stall_o, 1'b0);
        sb_pop_check("rr_fill_data");
        // Line 0 must not have been filled by the stray ack.
        fetch(32'h0000_0000, 2, 1'b1);
        fetch(32'h0000_0010, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
